multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle datapath controller. Sequences fetch, decode, execute, memory and writeback over several cycles.
- Holds a full NZCV flag register and evaluates all ARM condition codes, not only EQ/NE/AL.
- Tolerates variable-latency memory through a MemReady handshake with a timeout fault, and counts retired instructions.
- Sits between the instruction register fields and the multi-cycle datapath muxes and enables.

Parameters:
- ALUCTRL_W, 4: width of ALUControl; must be >= 4. Codes are zero-extended.
- MEM_TIMEOUT, 0: maximum number of wait cycles per memory access; 0 disables the timeout.
- RETIRE_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Cond  in  4  instruction condition field [31:28].
- Op  in  2  instruction opcode [27:26].
- Funct  in  6  instruction function field [25:20]; Funct[0] is the S/L bit.
- Rd  in  4  destination register field.
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- MemReady  in  1  memory access completes this cycle.
- PCWrite  out  1  load PC.
- IRWrite  out  1  load instruction register.
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result register.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- RegWrite  out  1  register-file write.
- ResultSrc  out  2  result mux: 00 = ALUOut register, 01 = data register, 10 = ALU direct.
- ALUSrcA  out  2  ALU A mux: 00 = Rn, 01 = PC.
- ALUSrcB  out  2  ALU B mux: 00 = Rm/shifted, 01 = ExtImm, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = DP, 01 = memory, 10 = branch.
- RegSrc  out  3  register-address selects; same encoding as the single-cycle controller.
- WDSrc  out  1  write data = PC+4 (BL link).
- ALUControl  out  ALUCTRL_W  ALU operation: AND 0000, SUB 0010, ADD 0100, ORR 1100, MOV 1101, default MOV.
- Flags  out  4  stored {N,Z,C,V}.
- Fault  out  1  sticky memory-timeout fault.
- Retired  out  RETIRE_W  count of retired instructions.
- State  out  4  current state, for debug.

Behaviour:

Reset:
- On reset the state goes to FETCH, and Flags, Fault and Retired clear to 0.
- Reset overrides everything in the same edge, including a reset asserted mid-access.
- All control outputs are Moore-decoded from the state plus the latched decode. Every output not explicitly asserted in a state is 0, and ALUControl is MOV.

States:
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - Holds while MemReady=0.
  - When MemReady=1: IRWrite=1 and PCWrite=1 in that cycle, then go to DECODE.
- DECODE: latch CondOk from the stored Flags.
  - If CondOk=0: go to FETCH, Retired increments, no state is modified.
  - Else: Op=00 with Funct[4:1]=1001 goes to BX; Op=00 otherwise goes to EXEC; Op=01 goes to MEMADR; Op=10 goes to BRANCH; Op=11 goes to FETCH (treated as a NOP that still retires).
- EXEC:
  - Immediate when Funct[5]=1: ALUSrcB=01, ImmSrc=00; otherwise ALUSrcB=00.
  - ALUControl follows Funct[4:1].
  - Flag write at the end of the cycle, when S=1 or the instruction is CMP:
    - ADD, SUB and CMP write NZCV.
    - AND, ORR and MOV write N and Z only; C and V are preserved.
  - Next state: CMP goes to FETCH and retires; all others go to ALUWB.
  - Undefined Funct goes to FETCH with no writes.
- ALUWB: RegWrite=1, ResultSrc=00, then FETCH and retire. If Rd=15: PCWrite=1 as well, and RegWrite=0.
- MEMADR: ALUSrcB=01, ImmSrc=01, ALUControl=ADD, RegSrc=010. L=1 goes to MEMRD; L=0 goes to MEMWR.
- MEMRD: AdrSrc=1, MemRead=1. Holds until MemReady, then goes to MEMWB.
- MEMWB: RegWrite=1, ResultSrc=01, then FETCH and retire.
- MEMWR: AdrSrc=1, MemWrite=1, RegSrc=010. Holds until MemReady, then FETCH and retire.
- BRANCH: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - If Funct[4]=1 (BL): RegWrite=1, WDSrc=1, RegSrc=101.
  - Then FETCH and retire.
- BX: PCWrite=1, ResultSrc=10, ALUControl=MOV, then FETCH and retire.
- FAULT: all enables 0, Fault=1. Leaves only on reset.

Condition codes:
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z.
- GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- AL 1; 1111 = never.

Timeout:
- A wait counter resets on entry to FETCH, MEMRD and MEMWR, and increments each cycle MemReady=0.
- When MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with MemReady still 0, the next state is FAULT.
- A MemReady arriving on the limit cycle wins.

Retire counter:
- Retired increments exactly once per instruction, on the transition into FETCH. It wraps modulo 2^RETIRE_W.

Cycle counts (MemReady tied to 1):
- Data-processing: 4.
- CMP: 3.
- LDR: 5.
- STR: 4.
- B, BL, BX: 3.

Test Plan:
- Reset: assert reset mid-MEMRD -> next cycle State=FETCH, Flags=0000, Retired=0, Fault=0.
- SUBS then conditional branch: SUBS with ALUFlags=0100 (Z=1) -> Flags=0100. Then BNE -> DECODE goes to FETCH with no PCWrite, Retired +1. Then BEQ -> BRANCH with PCWrite=1.
- Flag preservation: ANDS with prior Flags=0011 and ALUFlags=1000 -> Flags=1011, C and V kept.
- GE/LT evaluation: Flags N=1, V=1 -> BGE taken, BLT skipped.
- Memory wait: LDR with MemReady low for 3 cycles in MEMRD -> MemRead held for 4 cycles, RegWrite=1 exactly once in MEMWB. Total 8 cycles.
- Timeout: MEM_TIMEOUT=4, MemReady stuck at 0 in FETCH -> FAULT after 4 wait cycles, Fault=1 and held until reset. Retired wraps at RETIRE_W=4 after 16 NOPs -> 0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Bundle between the instruction-register fields / datapath and the multi-cycle controller.
// The slave modport is the controller side; master is the datapath side.
interface multicycle_controller_if #(
  parameter int ALUCTRL_W = 4,
  parameter int RETIRE_W  = 16
);
  logic [3:0]           Cond;
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic [3:0]           Rd;
  logic [3:0]           ALUFlags;
  logic                 MemReady;
  logic                 PCWrite;
  logic                 IRWrite;
  logic                 AdrSrc;
  logic                 MemRead;
  logic                 MemWrite;
  logic                 RegWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [2:0]           RegSrc;
  logic                 WDSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [3:0]           Flags;
  logic                 Fault;
  logic [RETIRE_W-1:0]  Retired;
  logic [3:0]           State;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags, MemReady,
    input  PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, WDSrc, ALUControl, Flags, Fault,
           Retired, State
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags, MemReady,
    output PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, WDSrc, ALUControl, Flags, Fault,
           Retired, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle ARM-subset controller: FSM sequencing, NZCV flag register, full condition
// evaluation, memory wait/timeout handling and a retired-instruction counter.
module multicycle_controller #(
  parameter int ALUCTRL_W   = 4,
  parameter int MEM_TIMEOUT = 0,
  parameter int RETIRE_W    = 16
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.slave bus
);
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_SUB = 4'b0010;
  localparam logic [3:0] C_ADD = 4'b0100;
  localparam logic [3:0] C_CMP = 4'b1010;
  localparam logic [3:0] C_ORR = 4'b1100;
  localparam logic [3:0] C_MOV = 4'b1101;
  localparam logic [3:0] C_BX  = 4'b1001;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALUWB  = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8,
    S_BX     = 4'd9,
    S_FAULT  = 4'd10
  } state_t;

  state_t              state, nxt;
  logic [3:0]          flags;
  logic                fault;
  logic [RETIRE_W-1:0] retired;
  logic [5:0]          funct_q;
  logic [3:0]          rd_q;
  logic [CW-1:0]       wait_cnt;

  logic [3:0] cmd;
  logic       dp_ok, is_cmp, is_arith, cond_ok, timeout, flag_wr, retire;

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return cy;
      4'h3:    return !cy;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return cy && !z;
      4'h9:    return !cy || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // CMP runs the subtractor; anything unrecognised falls back to MOV.
  function automatic logic [ALUCTRL_W-1:0] alu_code(input logic [3:0] c);
    case (c)
      C_AND:   return ALUCTRL_W'(C_AND);
      C_SUB:   return ALUCTRL_W'(C_SUB);
      C_CMP:   return ALUCTRL_W'(C_SUB);
      C_ADD:   return ALUCTRL_W'(C_ADD);
      C_ORR:   return ALUCTRL_W'(C_ORR);
      default: return ALUCTRL_W'(C_MOV);
    endcase
  endfunction

  assign cmd      = funct_q[4:1];
  assign dp_ok    = (cmd == C_AND) || (cmd == C_SUB) || (cmd == C_ADD) ||
                    (cmd == C_ORR) || (cmd == C_MOV) || (cmd == C_CMP);
  assign is_cmp   = (cmd == C_CMP);
  assign is_arith = (cmd == C_ADD) || (cmd == C_SUB) || (cmd == C_CMP);
  assign cond_ok  = eval_cond(bus.Cond, flags);
  assign timeout  = (MEM_TIMEOUT > 0) && !bus.MemReady && (wait_cnt == CW'(MEM_TIMEOUT));
  assign flag_wr  = (state == S_EXEC) && dp_ok && (funct_q[0] || is_cmp);
  assign retire   = (nxt == S_FETCH) && (state != S_FETCH) && (state != S_FAULT);

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  if (bus.MemReady) nxt = S_DECODE;
                else if (timeout) nxt = S_FAULT;
      S_DECODE: if (!cond_ok) nxt = S_FETCH;
                else begin
                  case (bus.Op)
                    2'b00:   nxt = (bus.Funct[4:1] == C_BX) ? S_BX : S_EXEC;
                    2'b01:   nxt = S_MEMADR;
                    2'b10:   nxt = S_BRANCH;
                    default: nxt = S_FETCH;
                  endcase
                end
      S_EXEC:   nxt = (!dp_ok || is_cmp) ? S_FETCH : S_ALUWB;
      S_MEMADR: nxt = funct_q[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.MemReady) nxt = S_MEMWB;
                else if (timeout) nxt = S_FAULT;
      S_MEMWR:  if (bus.MemReady) nxt = S_FETCH;
                else if (timeout) nxt = S_FAULT;
      S_ALUWB, S_MEMWB, S_BRANCH, S_BX: nxt = S_FETCH;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      flags    <= '0;
      fault    <= 1'b0;
      retired  <= '0;
      funct_q  <= '0;
      rd_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state <= nxt;
      // Wait counter restarts on every state change, so each access gets a fresh budget.
      if (nxt != state)
        wait_cnt <= '0;
      else if (!bus.MemReady && (wait_cnt != {CW{1'b1}}))
        wait_cnt <= wait_cnt + CW'(1);
      if (state == S_DECODE) begin
        funct_q <= bus.Funct;
        rd_q    <= bus.Rd;
      end
      if (flag_wr)
        flags <= is_arith ? bus.ALUFlags : {bus.ALUFlags[3:2], flags[1:0]};
      if (nxt == S_FAULT)
        fault <= 1'b1;
      if (retire)
        retired <= retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ImmSrc     = 2'b00;
    bus.RegSrc     = 3'b000;
    bus.WDSrc      = 1'b0;
    bus.ALUControl = ALUCTRL_W'(C_MOV);
    case (state)
      S_FETCH: begin
        bus.MemRead    = 1'b1;
        bus.ALUSrcA    = 2'b01;
        bus.ALUSrcB    = 2'b10;
        bus.ALUControl = ALUCTRL_W'(C_ADD);
        bus.ResultSrc  = 2'b10;
        bus.IRWrite    = bus.MemReady;
        bus.PCWrite    = bus.MemReady;
      end
      S_EXEC: begin
        bus.ALUSrcB    = funct_q[5] ? 2'b01 : 2'b00;
        bus.ALUControl = alu_code(cmd);
      end
      S_ALUWB: begin
        // Writing r15 is a jump: steer the result into the PC instead of the file.
        if (rd_q == 4'd15) bus.PCWrite = 1'b1;
        else               bus.RegWrite = 1'b1;
      end
      S_MEMADR: begin
        bus.ALUSrcB    = 2'b01;
        bus.ImmSrc     = 2'b01;
        bus.ALUControl = ALUCTRL_W'(C_ADD);
        bus.RegSrc     = 3'b010;
      end
      S_MEMRD: begin
        bus.AdrSrc  = 1'b1;
        bus.MemRead = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite  = 1'b1;
        bus.ResultSrc = 2'b01;
      end
      S_MEMWR: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.RegSrc   = 3'b010;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = 2'b01;
        bus.ALUSrcB    = 2'b01;
        bus.ImmSrc     = 2'b10;
        bus.ALUControl = ALUCTRL_W'(C_ADD);
        bus.ResultSrc  = 2'b10;
        bus.PCWrite    = 1'b1;
        if (funct_q[4]) begin
          bus.RegWrite = 1'b1;
          bus.WDSrc    = 1'b1;
          bus.RegSrc   = 3'b101;
        end
      end
      S_BX: begin
        bus.PCWrite   = 1'b1;
        bus.ResultSrc = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.Flags   = flags;
  assign bus.Fault   = fault;
  assign bus.Retired = retired;
  assign bus.State   = state;
endmodule
